// File: rtl/vga_tile_fetcher.sv
// Two-level tile lookup (tile map -> tile bitmap) feeding the VGA output pins, with sideband delay and pellet blink.
// Optional TILE_COLORKEY_EN: tile pixels equal to KEY_COLOR are shown as BG_COLOR.
module vga_tile_fetcher #(
    parameter int                     MAP_COLS     = 80,
    parameter int                     MAP_ROWS     = 60,
    parameter int                     MAP_ADDR_W   = 13,
    parameter int                     TILE_ID_W    = 6,
    parameter int                     TILE_ADDR_W  = 12,
    parameter int                     PIX_W        = 12,
    parameter logic [PIX_W-1:0]       BG_COLOR     = 12'h000,
    parameter logic [TILE_ID_W-1:0]   BLINK_ID_MIN = 6'd48,
    parameter int                     BLINK_SHIFT  = 4,
    parameter bit                     SYNC_IDLE    = 1'b1
`ifdef TILE_COLORKEY_EN
    ,
    parameter logic [PIX_W-1:0]       KEY_COLOR    = 12'hF0F
`endif
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [9:0]             x_in,
    input  logic [9:0]             y_in,
    input  logic                   de_in,
    input  logic                   hs_in,
    input  logic                   vs_in,
    output logic [MAP_ADDR_W-1:0]  map_addr,
    input  logic [TILE_ID_W-1:0]   map_data,
    output logic [TILE_ADDR_W-1:0] tile_addr,
    input  logic [PIX_W-1:0]       tile_data,
    output logic [PIX_W-1:0]       rgb_out,
    output logic                   de_out,
    output logic                   hs_out,
    output logic                   vs_out,
    output logic [7:0]             frame_cnt
);

    logic [MAP_ADDR_W-1:0]  map_addr_q, map_addr_d;
    logic [TILE_ADDR_W-1:0] tile_addr_q, tile_addr_d;
    logic [PIX_W-1:0]       rgb_q, rgb_d;
    logic                   de_out_q, hs_out_q, vs_out_q;
    logic [3:0]             de_q, hs_q, vs_q, off_q;
    logic [5:0]             pix1_q, pix2_q;
    logic                   blink3_q, blink4_q, blink_d;
    logic                   offmap_d;
    logic                   vs_prev_q, vs_edge;
    logic [7:0]             frame_q, frame_d;

    // Bit 0 of each sideband vector is the stage captured with map_addr; bit 3 feeds the output register.
    always_comb begin
        map_addr_d  = MAP_ADDR_W'(32'(y_in[9:3]) * 32'(MAP_COLS) + 32'(x_in[9:3]));
        offmap_d    = (32'(x_in[9:3]) >= 32'(MAP_COLS)) || (32'(y_in[9:3]) >= 32'(MAP_ROWS));
        tile_addr_d = TILE_ADDR_W'({map_data, pix2_q});
        blink_d     = (map_data >= BLINK_ID_MIN) && frame_q[BLINK_SHIFT];
        vs_edge     = SYNC_IDLE ? (vs_prev_q && !vs_in) : (!vs_prev_q && vs_in);
        frame_d     = vs_edge ? frame_q + 8'd1 : frame_q;

        rgb_d = tile_data;
        if (!de_q[3]) begin
            rgb_d = '0;
        end else if (off_q[3] || blink4_q) begin
            rgb_d = BG_COLOR;
        end
`ifdef TILE_COLORKEY_EN
        else if (tile_data == KEY_COLOR) begin
            rgb_d = BG_COLOR;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            map_addr_q  <= '0;
            tile_addr_q <= '0;
            rgb_q       <= '0;
            de_out_q    <= 1'b0;
            hs_out_q    <= SYNC_IDLE;
            vs_out_q    <= SYNC_IDLE;
            de_q        <= '0;
            hs_q        <= {4{SYNC_IDLE}};
            vs_q        <= {4{SYNC_IDLE}};
            off_q       <= '0;
            pix1_q      <= '0;
            pix2_q      <= '0;
            blink3_q    <= 1'b0;
            blink4_q    <= 1'b0;
            vs_prev_q   <= SYNC_IDLE;
            frame_q     <= '0;
        end else begin
            map_addr_q  <= map_addr_d;
            tile_addr_q <= tile_addr_d;
            rgb_q       <= rgb_d;
            de_out_q    <= de_q[3];
            hs_out_q    <= hs_q[3];
            vs_out_q    <= vs_q[3];
            de_q        <= {de_q[2:0], de_in};
            hs_q        <= {hs_q[2:0], hs_in};
            vs_q        <= {vs_q[2:0], vs_in};
            off_q       <= {off_q[2:0], offmap_d};
            pix1_q      <= {y_in[2:0], x_in[2:0]};
            pix2_q      <= pix1_q;
            blink3_q    <= blink_d;
            blink4_q    <= blink3_q;
            vs_prev_q   <= vs_in;
            frame_q     <= frame_d;
        end
    end

    assign map_addr  = map_addr_q;
    assign tile_addr = tile_addr_q;
    assign rgb_out   = rgb_q;
    assign de_out    = de_out_q;
    assign hs_out    = hs_out_q;
    assign vs_out    = vs_out_q;
    assign frame_cnt = frame_q;

endmodule

// File: tb/tb_vga_tile_fetcher.sv
// Self-checking bench for vga_tile_fetcher: behavioural ROMs plus a per-pixel reference model of the lookup.
module tb_vga_tile_fetcher;

    localparam int MAXS = 2048;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [9:0]  x_in = '0, y_in = '0;
    logic        de_in = 1'b0, hs_in = 1'b1, vs_in = 1'b1;
    logic [12:0] map_addr;
    logic [5:0]  map_data;
    logic [11:0] tile_addr;
    logic [11:0] tile_data;
    logic [11:0] rgb_out;
    logic        de_out, hs_out, vs_out;
    logic [7:0]  frame_cnt;

    logic [5:0]  mapMem [0:8191];
    logic [11:0] tileMem [0:4095];

    int       sx [MAXS];
    int       sy [MAXS];
    int       sIdx [MAXS];
    bit       sde [MAXS], shs [MAXS], svs [MAXS], srst [MAXS], sOff [MAXS];
    bit [7:0] frameAfter [MAXS];

    int       cyc = 0;
    int       checks = 0;
    int       errors = 0;
    bit [7:0] frameM = 8'd0;
    bit       prevVsM = 1'b1;

    vga_tile_fetcher dut (
        .clk(clk), .reset_n(reset_n),
        .x_in(x_in), .y_in(y_in), .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
        .map_addr(map_addr), .map_data(map_data),
        .tile_addr(tile_addr), .tile_data(tile_data),
        .rgb_out(rgb_out), .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous ROMs: data follows the sampled address by one clock.
    always @(posedge clk) begin
        map_data  <= mapMem[map_addr];
        tile_data <= tileMem[tile_addr];
    end

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit rstWin(input int a, input int b);
        for (int i = a; i <= b; i++) begin
            if (i < 0 || srst[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int expTileAddr(input int s);
        return int'(mapMem[sIdx[s]]) * 64 + (sy[s] % 8) * 8 + (sx[s] % 8);
    endfunction

    function automatic logic [11:0] expRgb(input int s);
        int          id;
        logic [11:0] pix;
        bit [7:0]    fr;
        if (!sde[s]) return 12'h000;
        id  = int'(mapMem[sIdx[s]]);
        pix = tileMem[expTileAddr(s)];
        fr  = frameAfter[s + 1];
        if (sOff[s] || (id >= 48 && fr[4])) return 12'h000;
`ifdef TILE_COLORKEY_EN
        if (pix == 12'hF0F) return 12'h000;
`endif
        return pix;
    endfunction

    // Called at the negedge following edge m: compares every output against the model.
    task automatic checkOutput(input int m);
        int s;
        checkEq("frameCnt", frame_cnt, frameAfter[m]);
        if (srst[m]) begin
            checkEq("mapAddrReset", map_addr, 0);
            checkEq("tileAddrReset", tile_addr, 0);
        end else begin
            checkEq("mapAddr", map_addr, sIdx[m]);
            if (!rstWin(m - 2, m - 1) && sde[m - 2])
                checkEq("tileAddr", tile_addr, expTileAddr(m - 2));
        end
        s = m - 4;
        if (rstWin(s, m)) begin
            checkEq("rgbBlank", rgb_out, 0);
            checkEq("deBlank", de_out, 0);
            checkEq("hsIdle", hs_out, 1);
            checkEq("vsIdle", vs_out, 1);
        end else begin
            checkEq("rgb", rgb_out, expRgb(s));
            checkEq("de", de_out, sde[s]);
            checkEq("hs", hs_out, shs[s]);
            checkEq("vs", vs_out, svs[s]);
        end
    endtask

    task automatic applyStimulus(input int x, input int y, input bit de, input bit hs, input bit vs, input bit rstn);
        if (cyc >= MAXS) begin
            $display("[TB] FAIL stepBudget observed=%0d expected<%0d", cyc, MAXS);
            $fatal(1, "[TB] step budget exhausted");
        end
        x_in = 10'(x); y_in = 10'(y); de_in = de; hs_in = hs; vs_in = vs; reset_n = rstn;
        sx[cyc] = x; sy[cyc] = y; sde[cyc] = de; shs[cyc] = hs; svs[cyc] = vs; srst[cyc] = !rstn;
        sIdx[cyc] = ((y / 8) * 80 + (x / 8)) % 8192;
        sOff[cyc] = (x / 8 >= 80) || (y / 8 >= 60);
        if (!rstn) begin
            frameM = 8'd0; prevVsM = 1'b1;
        end else begin
            if (prevVsM && !vs) frameM = frameM + 8'd1;
            prevVsM = vs;
        end
        frameAfter[cyc] = frameM;
        if (!rstn) begin
            #1;
            checkEq("asyncRgb", rgb_out, 0);
            checkEq("asyncDe", de_out, 0);
            checkEq("asyncHs", hs_out, 1);
            checkEq("asyncVs", vs_out, 1);
            checkEq("asyncFrame", frame_cnt, 0);
            checkEq("asyncMapAddr", map_addr, 0);
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput(cyc);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
            applyStimulus(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mapMem[i] = 6'($urandom_range(0, 63));
        for (int i = 0; i < 4096; i++) tileMem[i] = 12'($urandom_range(0, 4095));
        mapMem[0]    = 6'd5;
        tileMem[320] = 12'h123;
        #2 reset_n = 1'b0;
        @(negedge clk);
        applyStimulus(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);

        // First pixel at the origin: map 0 -> tile 5 -> colour 123.
        applyStimulus(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkEq("originMapAddr", map_addr, 0);
        applyStimulus(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkEq("originTileAddr", tile_addr, 320);
        applyStimulus(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkEq("originRgb", rgb_out, 12'h123);
        checkEq("originDe", de_out, 1);
        idle(5);

        for (int x = 636; x <= 639; x++) begin
            applyStimulus(x, 479, 1'b1, 1'b1, 1'b1, 1'b1);
            checkEq("cornerMapAddr", map_addr, 4799);
        end
        idle(5);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(645, 100, 1'b1, 1'b1, 1'b1, 1'b1);
            if (i >= 4) checkEq("offmapBg", rgb_out, 0);
        end
        idle(5);

        for (int i = 0; i < 150; i++)
            applyStimulus($urandom_range(0, 700), $urandom_range(0, 520),
                          $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
        idle(5);

        pulses(16);
        checkEq("frameAfterPulses", frame_cnt, 16);
        idle(5);
        mapMem[0] = 6'd48;
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkEq("blinkId48", rgb_out, 0);
        idle(5);
        mapMem[0] = 6'd47;
        tileMem[47 * 64] = 12'h456;
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkEq("noBlinkId47", rgb_out, 12'h456);
        idle(5);

        mapMem[0]  = 6'd10;
        tileMem[640] = 12'hF0F;
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
`ifdef TILE_COLORKEY_EN
        checkEq("colorKey", rgb_out, 12'h000);
`else
        checkEq("colorKey", rgb_out, 12'hF0F);
`endif

        // Mid-line reset while live pixels are in flight.
        for (int i = 0; i < 6; i++) applyStimulus(8 + i, 8, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(16, 8, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(17 + i, 8, 1'b1, 1'b1, 1'b1, 1'b1);
            checkEq("postResetBlank", de_out, 0);
        end
        applyStimulus(21, 8, 1'b1, 1'b1, 1'b1, 1'b1);
        checkEq("postResetLive", de_out, 1);
        idle(5);

        pulses(16);
        for (int i = 0; i < 250; i++)
            applyStimulus($urandom_range(0, 700), $urandom_range(0, 520),
                          $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 11) != 0, 1'b1);
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
